// File: rtl/alu_pkg.sv
// Shared widths, opcodes, NZCV bit positions and FSM state type for the ALU arbiter.
package alu_pkg;
   localparam int DATA_W = 8;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-facing request/response bundle; master = requesters, slave = arbiter.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [alu_pkg::DATA_W*NUM_REQ-1:0]  req_a;
   logic [alu_pkg::DATA_W*NUM_REQ-1:0]  req_b;
   logic [alu_pkg::OP_W*NUM_REQ-1:0]    req_op;
   logic [NUM_REQ-1:0]                  rsp_valid;
   logic [NUM_REQ-1:0]                  rsp_ready;
   logic [alu_pkg::DATA_W-1:0]          rsp_result;
   logic [3:0]                          rsp_nzcv;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_nzcv
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_nzcv
   );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
// No state; the rotation pointer is owned by the caller.
module rr_arbiter #(
   parameter int  N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);
   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU: grant->EXEC->RESP, response 2 cycles after accept, min 3 cycles/op.
// A stalled response holds RESP and blocks all requesters; ALU_ARB_FLAGS_EN adds per-requester flags_out.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int  NUM_REQ = 2,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_arbiter_if.slave      bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_nzcv,
   output logic              busy
`ifdef ALU_ARB_FLAGS_EN
   ,
   output logic [4*NUM_REQ-1:0] flags_out
`endif
);
   state_t              state;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       pick_idx;
   logic                pick_found;
   logic [DATA_W-1:0]   rsp_result_q;
   logic [3:0]          rsp_nzcv_q;
   logic                rsp_done;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign bus.req_ready  = (state == IDLE) ? grant : '0;
   assign bus.rsp_valid  = (state == RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_nzcv   = rsp_nzcv_q;
   assign busy           = (state != IDLE);
   // Only the granted requester's rsp_ready can complete the response.
   assign rsp_done       = (state == RESP) && bus.rsp_ready[gnt_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         gnt_idx      <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         rsp_result_q <= '0;
         rsp_nzcv_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  alu_a   <= bus.req_a[pick_idx*DATA_W +: DATA_W];
                  alu_b   <= bus.req_b[pick_idx*DATA_W +: DATA_W];
                  alu_op  <= bus.req_op[pick_idx*OP_W +: OP_W];
                  gnt_idx <= pick_idx;
                  rr_ptr  <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                  state   <= EXEC;
               end
            end
            EXEC: begin
               rsp_result_q <= alu_result;
               rsp_nzcv_q   <= alu_nzcv;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_FLAGS_EN
   logic [4*NUM_REQ-1:0] flags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (rsp_done) begin
         flags_q[gnt_idx*4 +: 4] <= rsp_nzcv_q;
      end
   end

   assign flags_out = flags_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NUM_REQ=2 and a behavioural 8-bit ALU beside it.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic [3:0] alu_nzcv;
   logic       busy;
`ifdef ALU_ARB_FLAGS_EN
   logic [7:0] flags_out;
`endif
   int n_checks = 0;
   int n_errors = 0;

   alu_arbiter_if #(.NUM_REQ(2)) bus ();

   alu_arbiter #(.NUM_REQ(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_nzcv   (alu_nzcv),
      .busy       (busy)
`ifdef ALU_ARB_FLAGS_EN
      ,
      .flags_out  (flags_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
      logic [8:0] w;
      logic [7:0] r;
      logic [3:0] f;
      w = '0;
      r = a;
      f = '0;
      case (op)
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[7:0];
            f[FLAG_C] = w[8];
            f[FLAG_V] = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_SUB: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[7:0];
            f[FLAG_C] = w[8];
            f[FLAG_V] = (a[7] != b[7]) && (r[7] != a[7]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SHL: begin
            r = {a[6:0], 1'b0};
            f[FLAG_C] = a[7];
         end
         OP_SHR: begin
            r = {1'b0, a[7:1]};
            f[FLAG_C] = a[0];
         end
         default: r = a;
      endcase
      f[FLAG_N] = r[7];
      f[FLAG_Z] = (r == 8'h00);
      return {r, f};
   endfunction

   always_comb {alu_result, alu_nzcv} = alu_model(alu_a, alu_b, alu_op);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] er, input logic [3:0] en,
                         input string tag);
      logic [1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      bus.req_a[8*idx +: 8]  = a;
      bus.req_b[8*idx +: 8]  = b;
      bus.req_op[3*idx +: 3] = op;
      bus.req_valid[idx]     = 1'b1;
      bus.rsp_ready          = 2'b11;
      #1;
      for (int k = 0; k < 8 && bus.req_ready !== oh; k++) begin
         cyc();
         #1;
      end
      check({tag, "_grant"}, 32'(bus.req_ready), 32'(oh));
      cyc();
      bus.req_valid[idx] = 1'b0;
      #1;
      check({tag, "_exec_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
      cyc();
      #1;
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
      check({tag, "_result"}, 32'(bus.rsp_result), 32'(er));
      check({tag, "_nzcv"}, 32'(bus.rsp_nzcv), 32'(en));
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '0;
      cyc();
      cyc();
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_alu_abop", {8'h00, alu_a, alu_b, 5'd0, alu_op}, 32'd0);
      check("rst_rsp", {20'd0, bus.rsp_result, bus.rsp_nzcv}, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Single add from r0: 0x7F + 0x01 overflows into the sign bit.
      bus.req_valid = 2'b01;
      bus.req_a     = 16'h007F;
      bus.req_b     = 16'h0001;
      bus.req_op    = 6'b000_000;
      bus.rsp_ready = 2'b11;
      #1;
      check("add_req_ready", 32'(bus.req_ready), 32'h1);
      cyc();
      bus.req_valid = 2'b00;
      #1;
      check("add_exec_busy", 32'(busy), 32'd1);
      check("add_exec_req_ready", 32'(bus.req_ready), 32'd0);
      check("add_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("add_alu_a", 32'(alu_a), 32'h7F);
      cyc();
      #1;
      check("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("add_result", 32'(bus.rsp_result), 32'h80);
      check("add_nzcv", 32'(bus.rsp_nzcv), 32'h9);
      cyc();
      #1;
      check("add_done_busy", 32'(busy), 32'd0);
      check("add_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);

      // Backpressure: r1 SHL 0x81 stalls 5 cycles, r0 waits, r0's rsp_ready is ignored.
      bus.req_valid = 2'b10;
      bus.req_a     = 16'h8101;
      bus.req_b     = 16'h0002;
      bus.req_op    = 6'b101_000;
      bus.rsp_ready = 2'b01;
      #1;
      check("bp_grant_r1", 32'(bus.req_ready), 32'h2);
      cyc();
      bus.req_valid = 2'b01;
      #1;
      check("bp_exec_req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      for (int s = 0; s < 5; s++) begin
         #1;
         check("bp_stall_rsp_valid", 32'(bus.rsp_valid), 32'h2);
         check("bp_stall_result", 32'(bus.rsp_result), 32'h02);
         check("bp_stall_nzcv", 32'(bus.rsp_nzcv), 32'h4);
         check("bp_stall_req_ready", 32'(bus.req_ready), 32'd0);
         cyc();
      end
      bus.rsp_ready = 2'b11;
      #1;
      check("bp_hs_rsp_valid", 32'(bus.rsp_valid), 32'h2);
      cyc();
      #1;
      check("bp_r0_grant_next", 32'(bus.req_ready), 32'h1);
      cyc();
      bus.req_valid = 2'b00;
      cyc();
      #1;
      check("bp_r0_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_r0_result", 32'(bus.rsp_result), 32'h03);
      check("bp_r0_nzcv", 32'(bus.rsp_nzcv), 32'h0);
      cyc();

      // Reset during EXEC drops the in-flight r1 operation.
      bus.req_valid = 2'b10;
      bus.req_a     = 16'h1000;
      bus.req_b     = 16'h2000;
      bus.req_op    = 6'b000_000;
      cyc();
      bus.req_valid = 2'b00;
      #1;
      check("mid_exec_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_alu", {8'h00, alu_a, alu_b, 5'd0, alu_op}, 32'd0);
      check("mid_rst_rsp", {20'd0, bus.rsp_result, bus.rsp_nzcv}, 32'd0);
      check("mid_rst_valid", {30'd0, bus.rsp_valid}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      #1;
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      run_op(0, 8'h00, 8'h55, OP_PASS, 8'h00, 4'h2, "pass_zero");

      // Withdrawn request: r0 pulses valid while r1 is busy, then drops it.
      bus.req_valid = 2'b10;
      bus.req_a     = 16'h0F00;
      bus.req_b     = 16'h3000;
      bus.req_op    = 6'b011_000;
      bus.rsp_ready = 2'b11;
      #1;
      check("wd_grant_r1", 32'(bus.req_ready), 32'h2);
      cyc();
      bus.req_valid = 2'b01;
      #1;
      check("wd_busy_req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      bus.req_valid = 2'b00;
      #1;
      check("wd_rsp_valid", 32'(bus.rsp_valid), 32'h2);
      check("wd_result", 32'(bus.rsp_result), 32'h3F);
      cyc();
      cyc();
      #1;
      check("wd_no_grant_busy", 32'(busy), 32'd0);
      check("wd_alu_a_held", 32'(alu_a), 32'h0F);

      // Contention: both valid continuously, grants alternate starting with r0.
      bus.req_a     = 16'hFFF0;
      bus.req_b     = 16'hFF3C;
      bus.req_op    = 6'b100_010;
      bus.req_valid = 2'b11;
      #1;
      for (int n = 0; n < 6; n++) begin
         logic [1:0] oh;
         oh = (n % 2 == 0) ? 2'b01 : 2'b10;
         check("cont_grant", 32'(bus.req_ready), 32'(oh));
         cyc();
         cyc();
         #1;
         check("cont_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
         check("cont_result", 32'(bus.rsp_result), (n % 2 == 0) ? 32'h30 : 32'h00);
         check("cont_nzcv", 32'(bus.rsp_nzcv), (n % 2 == 0) ? 32'h0 : 32'h2);
         cyc();
         #1;
      end
      bus.req_valid = 2'b00;
      cyc();

`ifdef ALU_ARB_FLAGS_EN
      run_op(0, 8'h05, 8'h05, OP_SUB, 8'h00, 4'h2, "flg_sub");
      run_op(1, 8'h80, 8'h01, OP_OR, 8'h81, 4'h1, "flg_or");
      #1;
      check("flags_out", 32'(flags_out), 32'h12);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
